// File: rtl/cd_dict_engine.sv
// Dictionary compression engine: maps symbols to indices with a one-entry-per-cycle scan.
// Optional macro CD_DICT_REPLACE_EN: a full-dictionary miss overwrites entries round-robin.
module cd_dict_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        command,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  compressed_in,
    output logic [IDX_W-1:0]  compressed_out,
    output logic [DATA_W-1:0] decompressed_out,
    output logic [1:0]        response,
    output logic              busy
);

    typedef enum logic {IDLE, SEARCH} state_t;

    localparam logic [1:0] CMD_COMPRESS   = 2'b01;
    localparam logic [1:0] CMD_DECOMPRESS = 2'b10;
    localparam logic [1:0] CMD_CLEAR      = 2'b11;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_COMP = 2'b01;
    localparam logic [1:0] RSP_DECO = 2'b10;
    localparam logic [1:0] RSP_ERR  = 2'b11;

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

    logic [DATA_W-1:0] dict [DEPTH];
    state_t            state;
    logic [IDX_W:0]    count;
    logic [IDX_W:0]    scan_ptr;
    logic [DATA_W-1:0] data_q;
`ifdef CD_DICT_REPLACE_EN
    logic [IDX_W-1:0]  repl_ptr;
`endif

    // Dictionary contents survive reset; clearing count alone invalidates every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            scan_ptr         <= '0;
            compressed_out   <= '0;
            decompressed_out <= '0;
            response         <= RSP_NONE;
            busy             <= 1'b0;
`ifdef CD_DICT_REPLACE_EN
            repl_ptr         <= '0;
`endif
        end else begin
            response <= RSP_NONE;
            case (state)
                IDLE: begin
                    case (command)
                        CMD_COMPRESS: begin
                            data_q   <= data_in;
                            scan_ptr <= '0;
                            state    <= SEARCH;
                            busy     <= 1'b1;
                        end
                        CMD_DECOMPRESS: begin
                            if ({1'b0, compressed_in} < count) begin
                                decompressed_out <= dict[compressed_in];
                                response         <= RSP_DECO;
                            end else begin
                                response <= RSP_ERR;
                            end
                        end
                        CMD_CLEAR: begin
                            count <= '0;
`ifdef CD_DICT_REPLACE_EN
                            repl_ptr <= '0;
`endif
                        end
                        default: ;
                    endcase
                end
                SEARCH: begin
                    if (scan_ptr < count) begin
                        if (dict[scan_ptr[IDX_W-1:0]] == data_q) begin
                            compressed_out <= scan_ptr[IDX_W-1:0];
                            response       <= RSP_COMP;
                            state          <= IDLE;
                            busy           <= 1'b0;
                        end else begin
                            scan_ptr <= scan_ptr + ONE;
                        end
                    end else if (count != FULL) begin
                        // Miss with room left: append at the first free slot.
                        dict[count[IDX_W-1:0]] <= data_q;
                        compressed_out         <= count[IDX_W-1:0];
                        count                  <= count + ONE;
                        response               <= RSP_COMP;
                        state                  <= IDLE;
                        busy                   <= 1'b0;
                    end else begin
`ifdef CD_DICT_REPLACE_EN
                        dict[repl_ptr] <= data_q;
                        compressed_out <= repl_ptr;
                        repl_ptr       <= repl_ptr + 1'b1;
                        response       <= RSP_COMP;
`else
                        response <= RSP_ERR;
`endif
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cd_dict_engine.sv
// Self-checking bench for cd_dict_engine (DATA_W=8, DEPTH=4) with a queue-level model.
// Build with CD_DICT_REPLACE_EN defined to exercise the replacement variant.
module tb_cd_dict_engine;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;

    localparam logic [1:0] NOP    = 2'b00;
    localparam logic [1:0] COMP   = 2'b01;
    localparam logic [1:0] DECOMP = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        command = NOP;
    logic [DATA_W-1:0] data_in = '0;
    logic [IDX_W-1:0]  compressed_in = '0;
    logic [IDX_W-1:0]  compressed_out;
    logic [DATA_W-1:0] decompressed_out;
    logic [1:0]        response;
    logic              busy;

    int checks = 0;
    int errors = 0;

    cd_dict_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .command          (command),
        .data_in          (data_in),
        .compressed_in    (compressed_in),
        .compressed_out   (compressed_out),
        .decompressed_out (decompressed_out),
        .response         (response),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: the dictionary is a plain array plus fill level; a COMPRESS result is decided
    // when issued and released after its scan latency (hit index + 1, or fill level + 1).
    logic [7:0] mdict [DEPTH];
    int         msize = 0;
    int         mrepl = 0;
    int         mwait = 0;
    logic [1:0] exp_resp = '0;
    logic [1:0] exp_cout = '0;
    logic [7:0] exp_dout = '0;
    logic       exp_busy = 1'b0;
    logic [1:0] p_resp = '0;
    int         p_idx = 0;
    bit         p_store = 0, p_grow = 0, p_repl = 0;
    logic [7:0] p_data = '0;
    bit         model_on = 0;

    always @(posedge clk) begin : model
        int hit;
        exp_resp = 2'b00;
        if (reset) begin
            exp_cout = '0;
            exp_dout = '0;
            exp_busy = 1'b0;
            msize    = 0;
            mrepl    = 0;
            mwait    = 0;
            model_on = 1;
        end else if (mwait > 0) begin
            mwait--;
            if (mwait == 0) begin
                exp_busy = 1'b0;
                exp_resp = p_resp;
                if (p_resp == 2'b01) exp_cout = 2'(p_idx);
                if (p_store) mdict[p_idx] = p_data;
                if (p_grow) msize++;
                if (p_repl) mrepl = (mrepl + 1) % DEPTH;
            end
        end else begin
            case (command)
                COMP: begin
                    hit = -1;
                    for (int i = 0; i < msize; i++)
                        if (hit < 0 && mdict[i] == data_in) hit = i;
                    p_data  = data_in;
                    p_store = 0;
                    p_grow  = 0;
                    p_repl  = 0;
                    p_resp  = 2'b01;
                    if (hit >= 0) begin
                        p_idx = hit;
                        mwait = hit + 1;
                    end else begin
                        mwait = msize + 1;
                        if (msize < DEPTH) begin
                            p_idx   = msize;
                            p_store = 1;
                            p_grow  = 1;
                        end else begin
`ifdef CD_DICT_REPLACE_EN
                            p_idx   = mrepl;
                            p_store = 1;
                            p_repl  = 1;
`else
                            p_idx  = 0;
                            p_resp = 2'b11;
`endif
                        end
                    end
                    exp_busy = 1'b1;
                end
                DECOMP: begin
                    if (int'(compressed_in) < msize) begin
                        exp_dout = mdict[compressed_in];
                        exp_resp = 2'b10;
                    end else begin
                        exp_resp = 2'b11;
                    end
                end
                CLEAR: begin
                    msize = 0;
                    mrepl = 0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("cyc_busy", busy, exp_busy);
            checkOutput("cyc_response", response, exp_resp);
            checkOutput("cyc_compressed_out", compressed_out, exp_cout);
            checkOutput("cyc_decompressed_out", decompressed_out, exp_dout);
        end
    end

    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] d, input logic [1:0] ci);
        @(negedge clk);
        command       = cmd;
        data_in       = d;
        compressed_in = ci;
        @(negedge clk);
        command = NOP;
    endtask

    task automatic waitResponse(output int lat, output logic [1:0] rsp);
        lat = -1;
        rsp = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (response != 2'b00) begin
                lat = i;
                rsp = response;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_timeout: got no response, expected one within 12 cycles");
        end
    endtask

    task automatic doCompress(input string name, input logic [7:0] d, input int exp_lat,
                              input int exp_rsp, input int exp_idx);
        int         lat;
        logic [1:0] rsp;
        applyStimulus(COMP, d, 2'b00);
        waitResponse(lat, rsp);
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_response"}, rsp, exp_rsp);
        checkOutput({name, "_index"}, compressed_out, exp_idx);
    endtask

    task automatic doDecompress(input string name, input logic [1:0] idx,
                                input int exp_rsp, input int exp_data);
        applyStimulus(DECOMP, 8'h00, idx);
        checkOutput({name, "_response"}, response, exp_rsp);
        checkOutput({name, "_data"}, decompressed_out, exp_data);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int pulses;
        int last_idx;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_response", response, 0);
        checkOutput("reset_cout", compressed_out, 0);
        checkOutput("reset_dout", decompressed_out, 0);

        doCompress("a5_miss", 8'hA5, 1, 2'b01, 0);
        doCompress("a5_hit", 8'hA5, 1, 2'b01, 0);
        doCompress("x11_miss", 8'h11, 2, 2'b01, 1);
        doDecompress("dec1", 2'd1, 2'b10, 8'h11);
        doDecompress("dec3_invalid", 2'd3, 2'b11, 8'h11);
        doCompress("x22_miss", 8'h22, 3, 2'b01, 2);
        doCompress("x33_miss", 8'h33, 4, 2'b01, 3);
        doCompress("x33_hit", 8'h33, 4, 2'b01, 3);
        doDecompress("dec2", 2'd2, 2'b10, 8'h22);

        // Second COMPRESS lands while the first is still scanning and must vanish.
        applyStimulus(COMP, 8'h33, 2'b00);
        applyStimulus(COMP, 8'h99, 2'b00);
        pulses   = 0;
        last_idx = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (response != 2'b00) begin
                pulses++;
                last_idx = int'(compressed_out);
            end
        end
        checkOutput("busy_drop_pulses", pulses, 1);
        checkOutput("busy_drop_index", last_idx, 3);

`ifdef CD_DICT_REPLACE_EN
        doCompress("full_x44", 8'h44, 5, 2'b01, 0);
        doDecompress("dec0_after_replace", 2'd0, 2'b10, 8'h44);
        doCompress("full_x55", 8'h55, 5, 2'b01, 1);
`else
        doCompress("full_x44", 8'h44, 5, 2'b11, 3);
        doDecompress("dec0_after_full", 2'd0, 2'b10, 8'hA5);
`endif

        applyStimulus(CLEAR, 8'h00, 2'b00);
        checkOutput("clear_response", response, 0);
        doDecompress("dec0_after_clear", 2'd0, 2'b11, decompressed_out);
        doCompress("x77_after_clear", 8'h77, 1, 2'b01, 0);
        doCompress("x88_miss", 8'h88, 2, 2'b01, 1);
        doCompress("x99_miss", 8'h99, 3, 2'b01, 2);

        applyStimulus(COMP, 8'hEE, 2'b00);
        repeat (2) @(negedge clk);
        checkOutput("midscan_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midscan_reset_busy", busy, 0);
        checkOutput("midscan_reset_response", response, 0);
        checkOutput("midscan_reset_cout", compressed_out, 0);
        checkOutput("midscan_reset_dout", decompressed_out, 0);
        doDecompress("dec0_after_reset", 2'd0, 2'b11, 8'h00);
        doCompress("x5a_after_reset", 8'h5A, 1, 2'b01, 0);
        doDecompress("dec0_x5a", 2'd0, 2'b10, 8'h5A);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
